// File: rtl/edge_pkg.sv
// Shared event encoding and hold-width helpers for the edge_to_level slice.
package edge_pkg;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_RISE = 2'd1,
    EV_FALL = 2'd2
  } event_t;

  // Legal range of MIN_HIGH / MIN_LOW is MIN_WIDTH .. 2**CNT_W
  localparam int MIN_WIDTH = 1;

  // Simultaneous rise and down encode as EV_NONE; the caller flags them separately.
  function automatic event_t encode_event(input logic rise, input logic down);
    case ({rise, down})
      2'b10:   return EV_RISE;
      2'b01:   return EV_FALL;
      default: return EV_NONE;
    endcase
  endfunction

  // Hold-counter load value for a width, clamped into the counter's range.
  function automatic int hold_load(input int width, input int cnt_w);
    int max_width;
    max_width = 1 << cnt_w;
    if (width < MIN_WIDTH) return 0;
    if (width > max_width) return max_width - 1;
    return width - 1;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that stops at zero; zero is a combinational decode of the register.
module hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/edge_to_level.sv
// Rebuilds a level from rise/down event pulses with minimum widths, a one-deep
// pending event, and error/glitch reporting for inconsistent event streams.
module edge_to_level
  import edge_pkg::*;
#(
  parameter int   MIN_HIGH   = 1,
  parameter int   MIN_LOW    = 1,
  parameter int   CNT_W      = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rise,
  input  logic             down,
  output logic             level,
  output logic             busy,
  output logic             err_dup,
  output logic             err_both,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] LOAD_HIGH = CNT_W'(hold_load(MIN_HIGH, CNT_W));
  localparam logic [CNT_W-1:0] LOAD_LOW  = CNT_W'(hold_load(MIN_LOW, CNT_W));

  event_t           ev;
  logic             both;
  logic             ev_dir;
  logic             target;
  logic             apply_pending;
  logic             timer_zero;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;

  logic             pend_valid;
  logic             pend_dir;
  logic             level_next;
  logic             pend_valid_next;
  logic             pend_dir_next;
  logic             dup_next;
  logic             both_next;
  logic             glitch_next;

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .zero     (timer_zero)
  );

  assign ev            = encode_event(rise, down);
  assign both          = rise & down;
  assign ev_dir        = (ev == EV_RISE);
  assign apply_pending = timer_zero & pend_valid;
  assign target        = pend_valid ? pend_dir : level;
  assign busy          = !timer_zero | pend_valid;

  always_comb begin
    level_next      = level;
    pend_valid_next = pend_valid;
    pend_dir_next   = pend_dir;
    dup_next        = 1'b0;
    both_next       = 1'b0;
    glitch_next     = 1'b0;

    // A due pending event applies regardless of what arrives this cycle.
    if (apply_pending) begin
      level_next      = pend_dir;
      pend_valid_next = 1'b0;
    end

    if (both) begin
      both_next = 1'b1;
    end else if (ev != EV_NONE) begin
      if (ev_dir == target) begin
        dup_next = 1'b1;
      end else if (pend_valid) begin
        if (apply_pending) begin
          // Fresh opposite event queues behind the one being applied.
          pend_valid_next = 1'b1;
          pend_dir_next   = ev_dir;
        end else begin
          pend_valid_next = 1'b0;
          glitch_next     = 1'b1;
        end
      end else if (timer_zero) begin
        level_next = ev_dir;
      end else begin
        pend_valid_next = 1'b1;
        pend_dir_next   = ev_dir;
      end
    end

    timer_load     = (level_next != level);
    timer_load_val = level_next ? LOAD_HIGH : LOAD_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= INIT_LEVEL;
      pend_valid <= 1'b0;
      pend_dir   <= 1'b0;
      err_dup    <= 1'b0;
      err_both   <= 1'b0;
      glitch     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      level      <= level_next;
      pend_valid <= pend_valid_next;
      pend_dir   <= pend_dir_next;
      err_dup    <= dup_next;
      err_both   <= both_next;
      glitch     <= glitch_next;
      if (glitch_next && (glitch_cnt != '1)) begin
        glitch_cnt <= glitch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_edge_to_level.sv
// Directed bench for edge_to_level: a vector table plus hand sequences on several parameterisations.
module tb_edge_to_level;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst4_n;

  // u0: defaults (1/1, INIT 0)
  logic r0, d0, l0, b0, ed0, eb0, g0;
  logic [7:0] gc0;
  // u1: MIN_HIGH=3
  logic r1, d1, l1, b1, ed1, eb1, g1;
  logic [7:0] gc1;
  // u2: MIN_HIGH=4
  logic r2, d2, l2, b2, ed2, eb2, g2;
  logic [7:0] gc2;
  // u3: CNT_W=2, MIN 4/4
  logic r3, d3, l3, b3, ed3, eb3, g3;
  logic [1:0] gc3;
  // u4: INIT_LEVEL=1, MIN_LOW=4, own reset
  logic r4, d4, l4, b4, ed4, eb4, g4;
  logic [7:0] gc4;

  edge_to_level u0 (.clk(clk), .rst_n(rst_n), .rise(r0), .down(d0), .level(l0), .busy(b0),
                    .err_dup(ed0), .err_both(eb0), .glitch(g0), .glitch_cnt(gc0));
  edge_to_level #(.MIN_HIGH(3)) u1 (.clk(clk), .rst_n(rst_n), .rise(r1), .down(d1), .level(l1), .busy(b1),
                    .err_dup(ed1), .err_both(eb1), .glitch(g1), .glitch_cnt(gc1));
  edge_to_level #(.MIN_HIGH(4)) u2 (.clk(clk), .rst_n(rst_n), .rise(r2), .down(d2), .level(l2), .busy(b2),
                    .err_dup(ed2), .err_both(eb2), .glitch(g2), .glitch_cnt(gc2));
  edge_to_level #(.MIN_HIGH(4), .MIN_LOW(4), .CNT_W(2)) u3 (.clk(clk), .rst_n(rst_n), .rise(r3), .down(d3),
                    .level(l3), .busy(b3), .err_dup(ed3), .err_both(eb3), .glitch(g3), .glitch_cnt(gc3));
  edge_to_level #(.MIN_LOW(4), .INIT_LEVEL(1'b1)) u4 (.clk(clk), .rst_n(rst4_n), .rise(r4), .down(d4),
                    .level(l4), .busy(b4), .err_dup(ed4), .err_both(eb4), .glitch(g4), .glitch_cnt(gc4));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r;
    logic d;
    logic lvl;
    logic busy;
    logic dup;
    logic both;
    logic gl;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};  // rise applied
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // duplicate rise
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // fall applied
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // duplicate fall
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};  // both at level 0
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};  // both at level 1
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    {r0, d0, r1, d1, r2, d2, r3, d3, r4, d4} = '0;
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    #12;
    chk("reset u0 level", l0, 0);
    chk("reset u0 busy", b0, 0);
    chk("reset u0 gcnt", gc0, 0);
    chk("reset u4 level", l4, 1);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rst4_n = 1'b1;

    // Table-driven on u0
    for (int i = 0; i < 10; i++) begin
      r0 = tbl[i].r;
      d0 = tbl[i].d;
      tick();
      r0 = 1'b0;
      d0 = 1'b0;
      chk($sformatf("vec%0d level", i), l0, tbl[i].lvl);
      chk($sformatf("vec%0d busy", i), b0, tbl[i].busy);
      chk($sformatf("vec%0d err_dup", i), ed0, tbl[i].dup);
      chk($sformatf("vec%0d err_both", i), eb0, tbl[i].both);
      chk($sformatf("vec%0d glitch", i), g0, tbl[i].gl);
    end

    // u1: MIN_HIGH=3, rise then immediate down is deferred
    tick();
    r1 = 1'b1; tick(); r1 = 1'b0;
    chk("u1 e2 level", l1, 1); chk("u1 e2 busy", b1, 1);
    d1 = 1'b1; tick(); d1 = 1'b0;
    chk("u1 e3 level", l1, 1); chk("u1 e3 busy", b1, 1); chk("u1 e3 glitch", g1, 0);
    tick();
    chk("u1 e4 level", l1, 1); chk("u1 e4 busy", b1, 1);
    tick();
    chk("u1 e5 level", l1, 0); chk("u1 e5 busy", b1, 0);
    // pending apply with a simultaneous fresh opposite event
    r1 = 1'b1; tick(); r1 = 1'b0;
    chk("u1 p1 level", l1, 1);
    d1 = 1'b1; tick(); d1 = 1'b0;
    chk("u1 p2 level", l1, 1);
    tick();
    chk("u1 p3 busy", b1, 1);
    r1 = 1'b1; tick(); r1 = 1'b0;
    chk("u1 p4 level", l1, 0); chk("u1 p4 busy", b1, 1); chk("u1 p4 glitch", g1, 0);
    tick();
    chk("u1 p5 level", l1, 1); chk("u1 p5 busy", b1, 1);

    // u2: MIN_HIGH=4, pending down cancelled by rise
    tick();
    r2 = 1'b1; tick(); r2 = 1'b0;
    chk("u2 e2 level", l2, 1);
    d2 = 1'b1; tick(); d2 = 1'b0;
    chk("u2 e3 glitch", g2, 0);
    r2 = 1'b1; tick(); r2 = 1'b0;
    chk("u2 e4 glitch", g2, 1); chk("u2 e4 gcnt", gc2, 1); chk("u2 e4 level", l2, 1);
    chk("u2 e4 busy", b2, 1); chk("u2 e4 err_dup", ed2, 0);
    tick();
    chk("u2 e5 busy", b2, 0); chk("u2 e5 glitch", g2, 0); chk("u2 e5 level", l2, 1);

    // u3: CNT_W=2, glitch counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      logic dir;
      dir = (i % 2 == 0);
      r3 = dir; d3 = !dir; tick();
      chk($sformatf("u3 g%0d apply level", i), l3, dir);
      r3 = !dir; d3 = dir; tick();
      r3 = dir; d3 = !dir; tick();
      r3 = 1'b0; d3 = 1'b0;
      chk($sformatf("u3 g%0d glitch", i), g3, 1);
      chk($sformatf("u3 g%0d gcnt", i), gc3, (i + 1 > 3) ? 3 : i + 1);
      chk($sformatf("u3 g%0d level", i), l3, dir);
      tick();
      chk($sformatf("u3 g%0d glitch clr", i), g3, 0);
    end

    // u4: INIT_LEVEL=1, async reset in the middle of a hold
    chk("u4 post-rel level", l4, 1);
    d4 = 1'b1; tick(); d4 = 1'b0;
    chk("u4 fall level", l4, 0); chk("u4 fall busy", b4, 1);
    r4 = 1'b1; tick(); r4 = 1'b0;
    d4 = 1'b1; tick(); d4 = 1'b0;
    chk("u4 glitch", g4, 1); chk("u4 gcnt", gc4, 1); chk("u4 busy pre-rst", b4, 1);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("u4 async level", l4, 1);
    chk("u4 async busy", b4, 0);
    chk("u4 async gcnt", gc4, 0);
    chk("u4 async glitch", g4, 0);
    @(posedge clk);
    #1;
    rst4_n = 1'b1;
    tick();
    chk("u4 rel level", l4, 1);
    chk("u4 rel flags", {ed4, eb4, g4}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
